// File: rtl/motor_driver_nch.sv
// motor_driver_nch
//   N-channel H-bridge driver (L293-style: one enable plus two direction pins per
//   channel). Each channel takes a direction bit and a half-period word from the
//   balance loop. It produces a square-wave enable whose half-period is
//   period_q+1 cycles. The half-period word is reloaded only at half-period
//   boundaries. A zero period stops the channel, and a reversal coasts the
//   bridge for DEADTIME cycles. A global brake shorts all bridges
//   (en=in_a=in_b=1).
//
// Ports
//   clk        in   1                rising-edge system clock
//   reset      in   1                asynchronous, active-low reset
//   brake      in   1                global brake request (level)
//   ch_sign    in   NUM_CH           requested direction per channel (1 = forward)
//   ch_period  in   NUM_CH*PERIOD_W  half-period word; channel i at [i*PERIOD_W +: PERIOD_W]
//   en         out  NUM_CH           bridge enable
//   in_a       out  NUM_CH           bridge input A
//   in_b       out  NUM_CH           bridge input B
//   ch_dead    out  NUM_CH           high while the channel is coasting in dead-time
module motor_driver_nch #(
  parameter int NUM_CH   = 2,
  parameter int PERIOD_W = 8,
  parameter int DEADTIME = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       brake,
  input  logic [NUM_CH-1:0]          ch_sign,
  input  logic [NUM_CH*PERIOD_W-1:0] ch_period,
  output logic [NUM_CH-1:0]          en,
  output logic [NUM_CH-1:0]          in_a,
  output logic [NUM_CH-1:0]          in_b,
  output logic [NUM_CH-1:0]          ch_dead
);

  localparam int DW = $clog2(DEADTIME + 1);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEADTIME);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DEAD  = 2'd2;
  localparam logic [1:0] S_BRAKE = 2'd3;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]          state;
    logic [PERIOD_W-1:0] counter;
    logic [PERIOD_W-1:0] period_q;
    logic                dir_q;
    logic [DW-1:0]       dead_cnt;
    logic                en_r;
    logic                a_r;
    logic                b_r;
    logic                dead_r;
    logic [PERIOD_W-1:0] period_in;
    logic                sign_in;

    assign period_in = ch_period[i*PERIOD_W +: PERIOD_W];
    assign sign_in   = ch_sign[i];

    // The outputs are registered next to the state. Each transition therefore
    // writes the pin values of the state being entered.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state    <= S_IDLE;
        counter  <= '0;
        period_q <= '0;
        dir_q    <= 1'b0;
        dead_cnt <= '0;
        en_r     <= 1'b0;
        a_r      <= 1'b0;
        b_r      <= 1'b0;
        dead_r   <= 1'b0;
      end else if (brake) begin
        state  <= S_BRAKE;
        en_r   <= 1'b1;
        a_r    <= 1'b1;
        b_r    <= 1'b1;
        dead_r <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            dir_q <= sign_in;
            en_r  <= 1'b0;
            if (period_in != '0) begin
              state    <= S_RUN;
              period_q <= period_in;
              counter  <= '0;
              a_r      <= sign_in;
              b_r      <= ~sign_in;
            end else begin
              a_r <= 1'b0;
              b_r <= 1'b0;
            end
          end
          S_RUN: begin
            if (sign_in != dir_q) begin
              state    <= S_DEAD;
              dead_cnt <= DEAD_LOAD;
              en_r     <= 1'b0;
              a_r      <= 1'b0;
              b_r      <= 1'b0;
              dead_r   <= 1'b1;
            end else if (counter < period_q) begin
              counter <= counter + PERIOD_W'(1);
            end else begin
              counter  <= '0;
              period_q <= period_in;
              if (period_in == '0) begin
                state <= S_IDLE;
                en_r  <= 1'b0;
                a_r   <= 1'b0;
                b_r   <= 1'b0;
              end else begin
                en_r <= ~en_r;
              end
            end
          end
          S_DEAD: begin
            // The count is loaded with DEADTIME. The value 1 marks the last
            // coast cycle, when direction and period are sampled.
            if (dead_cnt == DW'(1)) begin
              dir_q    <= sign_in;
              period_q <= period_in;
              counter  <= '0;
              en_r     <= 1'b0;
              dead_r   <= 1'b0;
              if (period_in != '0) begin
                state <= S_RUN;
                a_r   <= sign_in;
                b_r   <= ~sign_in;
              end else begin
                state <= S_IDLE;
                a_r   <= 1'b0;
                b_r   <= 1'b0;
              end
            end else begin
              dead_cnt <= dead_cnt - DW'(1);
            end
          end
          default: begin
            // S_BRAKE with the brake released: coast through full dead-time.
            state    <= S_DEAD;
            dead_cnt <= DEAD_LOAD;
            en_r     <= 1'b0;
            a_r      <= 1'b0;
            b_r      <= 1'b0;
            dead_r   <= 1'b1;
          end
        endcase
      end
    end

    assign en[i]      = en_r;
    assign in_a[i]    = a_r;
    assign in_b[i]    = b_r;
    assign ch_dead[i] = dead_r;
  end

endmodule

// File: tb/tb_motor_driver_nch.sv
// Testbench for motor_driver_nch. It runs directed scenarios and then a
// randomized phase. Every cycle is checked against a behavioural per-channel
// model that tracks the remaining cycles of the current half-period and of
// the dead-time.
module tb_motor_driver_nch;
  localparam int NCH = 2;
  localparam int PW  = 8;
  localparam int DT  = 4;

  localparam int M_COAST = 0;
  localparam int M_DRIVE = 1;
  localparam int M_GAP   = 2;
  localparam int M_HOLD  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              brake;
  logic [NCH-1:0]    ch_sign;
  logic [NCH*PW-1:0] ch_period;
  logic [NCH-1:0]    en;
  logic [NCH-1:0]    in_a;
  logic [NCH-1:0]    in_b;
  logic [NCH-1:0]    ch_dead;

  int total = 0;
  int bad   = 0;

  int mode   [NCH];
  int m_dir  [NCH];
  int m_per  [NCH];
  int m_left [NCH];
  int m_en   [NCH];
  int m_gap  [NCH];

  motor_driver_nch #(.NUM_CH(NCH), .PERIOD_W(PW), .DEADTIME(DT)) dut (
    .clk       (clk),
    .reset     (reset),
    .brake     (brake),
    .ch_sign   (ch_sign),
    .ch_period (ch_period),
    .en        (en),
    .in_a      (in_a),
    .in_b      (in_b),
    .ch_dead   (ch_dead)
  );

  always #5 clk = ~clk;

  function automatic int per_of(int c);
    logic [PW-1:0] v;
    v = ch_period[c*PW +: PW];
    return int'(v);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mode[c] = M_COAST; m_dir[c] = 0; m_per[c] = 0;
      m_left[c] = 0; m_en[c] = 0; m_gap[c] = 0;
    end
  endtask

  // Start a drive phase with period p: enable low, full half-period ahead.
  task automatic start_drive(int c, int s, int p);
    m_dir[c] = s; m_per[c] = p;
    if (p == 0) mode[c] = M_COAST;
    else begin
      mode[c] = M_DRIVE; m_en[c] = 0; m_left[c] = p + 1;
    end
  endtask

  task automatic model_step();
    int s, p;
    if (!reset) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      s = int'(ch_sign[c]);
      p = per_of(c);
      if (brake) mode[c] = M_HOLD;
      else begin
        case (mode[c])
          M_COAST: start_drive(c, s, p);
          M_DRIVE: begin
            if (s != m_dir[c]) begin
              mode[c] = M_GAP; m_gap[c] = DT;
            end else begin
              m_left[c]--;
              if (m_left[c] == 0) begin
                m_per[c] = p;
                if (p == 0) mode[c] = M_COAST;
                else begin
                  m_en[c] = 1 - m_en[c]; m_left[c] = p + 1;
                end
              end
            end
          end
          M_GAP: begin
            m_gap[c]--;
            if (m_gap[c] == 0) start_drive(c, s, p);
          end
          default: begin
            mode[c] = M_GAP; m_gap[c] = DT;
          end
        endcase
      end
    end
  endtask

  task automatic check(string tag);
    logic [NCH-1:0] e_en, e_a, e_b, e_d;
    for (int c = 0; c < NCH; c++) begin
      case (mode[c])
        M_DRIVE: begin
          e_en[c] = m_en[c][0]; e_a[c] = m_dir[c][0];
          e_b[c] = ~m_dir[c][0]; e_d[c] = 1'b0;
        end
        M_GAP:  begin e_en[c] = 0; e_a[c] = 0; e_b[c] = 0; e_d[c] = 1; end
        M_HOLD: begin e_en[c] = 1; e_a[c] = 1; e_b[c] = 1; e_d[c] = 0; end
        default: begin e_en[c] = 0; e_a[c] = 0; e_b[c] = 0; e_d[c] = 0; end
      endcase
    end
    total++;
    assert (en === e_en) else begin
      bad++; $error("FAIL %s en observed=%b expected=%b", tag, en, e_en);
    end
    total++;
    assert (in_a === e_a) else begin
      bad++; $error("FAIL %s in_a observed=%b expected=%b", tag, in_a, e_a);
    end
    total++;
    assert (in_b === e_b) else begin
      bad++; $error("FAIL %s in_b observed=%b expected=%b", tag, in_b, e_b);
    end
    total++;
    assert (ch_dead === e_d) else begin
      bad++; $error("FAIL %s ch_dead observed=%b expected=%b", tag, ch_dead, e_d);
    end
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_step();
    #1 check(tag);
  endtask

  task automatic run(int n, string tag);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  task automatic set_ch(int c, logic s, int p);
    ch_sign[c] = s;
    ch_period[c*PW +: PW] = PW'(p);
  endtask

  // Pull reset low between clock edges and expect outputs to clear immediately.
  task automatic async_reset(string tag);
    #2 reset = 1'b0;
    model_reset();
    #1 check(tag);
    step(tag);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; brake = 1'b0; ch_sign = '0; ch_period = '0;
    model_reset();
    #12 check("reset");
    run(2, "reset_hold");
    reset = 1'b1;
    run(3, "idle");

    // 1: forward at period 3
    set_ch(0, 1'b1, 3);
    run(20, "t1_run");

    // 2: shorten the period mid half-period, then stop
    run(2, "t2_pre");
    set_ch(0, 1'b1, 1);
    run(12, "t2_short");
    set_ch(0, 1'b1, 0);
    run(10, "t2_stop");

    // 3: reversal inserts dead-time
    set_ch(0, 1'b1, 3);
    run(7, "t3_fwd");
    set_ch(0, 1'b0, 3);
    run(14, "t3_rev");

    // 4: both channels running, brake for 10 cycles
    set_ch(1, 1'b1, 2);
    run(9, "t4_run");
    brake = 1'b1;
    run(10, "t4_brake");
    brake = 1'b0;
    run(12, "t4_release");

    // 5: ch0 parked, ch1 toggling its sign every cycle
    set_ch(0, 1'b0, 0);
    run(12, "t5_park");
    set_ch(1, 1'b0, 5);
    for (int k = 0; k < 30; k++) begin
      ch_sign[1] = ~ch_sign[1];
      step("t5_toggle");
    end

    // 6: async reset during DEAD and during BRAKE
    set_ch(0, 1'b1, 3);
    set_ch(1, 1'b1, 4);
    run(8, "t6_run");
    ch_sign[0] = 1'b0;
    run(2, "t6_dead");
    async_reset("t6_rst_dead");
    run(6, "t6_after_dead");
    brake = 1'b1;
    run(3, "t6_brake");
    async_reset("t6_rst_brake");
    brake = 1'b0;
    run(8, "t6_after_brake");

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      brake = ($urandom_range(0, 24) == 0);
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 9) == 0) ch_sign[c] = ~ch_sign[c];
        if ($urandom_range(0, 11) == 0) set_ch(c, ch_sign[c], $urandom_range(0, 6));
      end
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
